// File: rtl/result_mailbox.sv
// Result mailbox on the core data port.
// Stores to the mailbox address are queued in a FIFO that a host drains over valid/ready.
// A load from the status address returns the done flag and the entry count.
// A store to the done address ends the run and sets a sticky done flag.
module result_mailbox #(
  parameter logic [31:0] MBOX_ADDR = 32'h800010F0,
  parameter logic [31:0] STAT_ADDR = 32'h800010F4,
  parameter logic [31:0] DONE_ADDR = 32'h800010F8,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              mem_addr_D,
  input  logic                     mem_write_D,
  input  logic                     mem_read_D,
  input  logic [31:0]              mem_wdata_D,
  output logic [31:0]              mem_rdata_D,
  output logic                     mem_stall_D,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [$clog2(DEPTH):0]   res_count,
  output logic                     done
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  typedef enum logic [0:0] {StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]       mem_q [DEPTH];

  logic              sel_mbox, sel_stat, sel_done;
  logic              full, empty;
  logic              push, pop;
  logic [IdxW-1:0]   wr_idx, rd_idx;
  logic [7:0]        count8;

  // Only the word address is decoded; byte offset bits are ignored.
  assign sel_mbox = (mem_addr_D[31:2] == MBOX_ADDR[31:2]);
  assign sel_stat = (mem_addr_D[31:2] == STAT_ADDR[31:2]);
  assign sel_done = (mem_addr_D[31:2] == DONE_ADDR[31:2]);

  assign wr_idx = wr_ptr_q[IdxW-1:0];
  assign rd_idx = rd_ptr_q[IdxW-1:0];

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);

  assign res_count = wr_ptr_q - rd_ptr_q;
  assign res_valid = !empty;
  assign res_data  = empty ? 32'h0 : mem_q[rd_idx];
  assign done      = (state_q == StDone);

  // Stall only while running; once done, mailbox stores are dropped without holding the core.
  // A same-cycle pop does not release it, so the push lands one cycle after the pop.
  assign mem_stall_D = (state_q == StRun) && mem_write_D && sel_mbox && full;
  assign push        = (state_q == StRun) && mem_write_D && sel_mbox && !full;
  assign pop         = res_valid && res_ready;

  // Status word: done in bit 31, count zero-extended into the low byte.
  always_comb begin
    count8              = '0;
    count8[PtrW-1:0]    = res_count;
    mem_rdata_D         = '0;
    if (mem_read_D && sel_stat) begin
      mem_rdata_D = {done, 15'b0, 8'b0, count8};
    end
  end

  // Next-state for pointers and the run/done FSM.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case (state_q)
      StRun: begin
        if (mem_write_D && sel_done && !mem_stall_D) state_d = StDone;
      end
      StDone: state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  // State, pointers and storage; reset clears the contents as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_idx] <= mem_wdata_D;
    end
  end

endmodule

// File: tb/tb_result_mailbox.sv
// Directed bench for result_mailbox with hand-computed expectations.
module tb_result_mailbox;

  localparam logic [31:0] Mbox  = 32'h800010F0;
  localparam logic [31:0] Stat  = 32'h800010F4;
  localparam logic [31:0] Done  = 32'h800010F8;
  localparam logic [31:0] Unmap = 32'h80001000;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr_D;
  logic        mem_write_D;
  logic        mem_read_D;
  logic [31:0] mem_wdata_D;
  logic [31:0] mem_rdata_D;
  logic        mem_stall_D;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_count;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  result_mailbox dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr_D  (mem_addr_D),
    .mem_write_D (mem_write_D),
    .mem_read_D  (mem_read_D),
    .mem_wdata_D (mem_wdata_D),
    .mem_rdata_D (mem_rdata_D),
    .mem_stall_D (mem_stall_D),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_count   (res_count),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_addr_D  = addr;
    mem_wdata_D = data;
    mem_write_D = 1'b1;
    @(posedge clk);
    #1;
    mem_write_D = 1'b0;
    mem_addr_D  = '0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_data"}, res_data, exp);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    mem_addr_D = addr;
    mem_read_D = 1'b1;
    #1;
    check(tag, mem_rdata_D, exp);
    @(posedge clk);
    #1;
    mem_read_D = 1'b0;
    mem_addr_D = '0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] t1_vals [5];
    t1_vals = '{32'h1, 32'h1, 32'h2, 32'h3, 32'h5};
    rst_n       = 1'b0;
    mem_addr_D  = '0;
    mem_write_D = 1'b0;
    mem_read_D  = 1'b0;
    mem_wdata_D = '0;
    res_ready   = 1'b0;
    #2;
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", res_data, 32'd0);
    check("rst_count", 32'(res_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stall", 32'(mem_stall_D), 32'd0);
    check("rst_rdata", mem_rdata_D, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: fill five, then drain in order.
    for (int i = 0; i < 5; i++) begin
      do_store(Mbox, t1_vals[i]);
      if (i == 0) check("t1_latency_valid", 32'(res_valid), 32'd1);
    end
    check("t1_count", 32'(res_count), 32'd5);
    for (int i = 0; i < 5; i++) pop_check("t1_pop", t1_vals[i]);
    @(negedge clk);
    #1;
    check("t1_empty_valid", 32'(res_valid), 32'd0);
    check("t1_empty_data", res_data, 32'd0);

    // T2: overflow stalls, released the cycle after a pop.
    for (int i = 0; i < 8; i++) do_store(Mbox, 32'h10 + 32'(i));
    check("t2_full_count", 32'(res_count), 32'd8);
    @(negedge clk);
    mem_addr_D  = Mbox;
    mem_wdata_D = 32'h99;
    mem_write_D = 1'b1;
    #1;
    check("t2_stall", 32'(mem_stall_D), 32'd1);
    @(posedge clk);
    #1;
    check("t2_held_count", 32'(res_count), 32'd8);
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    check("t2_stall_with_pop", 32'(mem_stall_D), 32'd1);
    check("t2_head", res_data, 32'h10);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("t2_after_pop_count", 32'(res_count), 32'd7);
    check("t2_stall_released", 32'(mem_stall_D), 32'd0);
    @(posedge clk);
    #1;
    mem_write_D = 1'b0;
    mem_addr_D  = '0;
    check("t2_accept_count", 32'(res_count), 32'd8);
    for (int i = 1; i < 8; i++) pop_check("t2_pop", 32'h10 + 32'(i));
    pop_check("t2_pop9", 32'h99);
    check("t2_drained", 32'(res_count), 32'd0);

    // T3: streaming push/pop across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_addr_D  = Mbox;
      mem_wdata_D = 32'h300 + 32'(i);
      mem_write_D = 1'b1;
      res_ready   = 1'b1;
      #1;
      check("t3_stall", 32'(mem_stall_D), 32'd0);
      check("t3_count", 32'(res_count), (i == 0) ? 32'd0 : 32'd1);
      check("t3_valid", 32'(res_valid), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) check("t3_data", res_data, 32'h300 + 32'(i - 1));
    end
    @(negedge clk);
    mem_write_D = 1'b0;
    mem_addr_D  = '0;
    #1;
    check("t3_last_data", res_data, 32'h313);
    check("t3_last_count", 32'(res_count), 32'd1);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("t3_end_count", 32'(res_count), 32'd0);

    // T6: status loads with four entries held.
    for (int i = 0; i < 4; i++) do_store(Mbox, 32'h600 + 32'(i));
    load_check("t6_stat", Stat, 32'h4);
    load_check("t6_unmapped", Unmap, 32'h0);
    load_check("t6_mbox_load", Mbox, 32'h0);
    load_check("t6_stat_byteoff", Stat | 32'h3, 32'h4);

    // T4: done store, later mailbox stores ignored.
    @(negedge clk);
    mem_addr_D  = Done;
    mem_wdata_D = 32'hAA;
    mem_write_D = 1'b1;
    #1;
    check("t4_done_before", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    mem_write_D = 1'b0;
    mem_addr_D  = '0;
    check("t4_done_after", 32'(done), 32'd1);
    do_store(Mbox, 32'h77);
    check("t4_ignored_count", 32'(res_count), 32'd4);
    load_check("t4_stat", Stat, 32'h80000004);
    pop_check("t4_drain", 32'h600);
    load_check("t4_stat_after_pop", Stat, 32'h80000003);
    check("t4_done_sticky", 32'(done), 32'd1);

    // T5: asynchronous reset mid-cycle.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_clear_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) do_store(Mbox, 32'hA1 + 32'(i));
    check("t5_count", 32'(res_count), 32'd3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(res_valid), 32'd0);
    check("t5_rst_count", 32'(res_count), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_data", res_data, 32'd0);
    #3;
    rst_n = 1'b1;
    do_store(Mbox, 32'hB1);
    do_store(Mbox, 32'hB2);
    pop_check("t5_post_rst", 32'hB1);

    // Reset releases a stall in progress.
    for (int i = 0; i < 7; i++) do_store(Mbox, 32'hC0 + 32'(i));
    check("t5_refill_count", 32'(res_count), 32'd8);
    @(negedge clk);
    mem_addr_D  = Mbox;
    mem_wdata_D = 32'hDD;
    mem_write_D = 1'b1;
    #1;
    check("t5_stall_on", 32'(mem_stall_D), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_stall_released", 32'(mem_stall_D), 32'd0);
    check("t5_stall_rst_count", 32'(res_count), 32'd0);
    mem_write_D = 1'b0;
    mem_addr_D  = '0;
    #1;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
